// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump sequencer: FSM encoding, header tag,
// and the geometry of the four snapshotted pipeline latches.
package debug_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_HEADER   = 3'd1;
  localparam state_t ST_LATCH    = 3'd2;
  localparam state_t ST_REG_ADDR = 3'd3;
  localparam state_t ST_REG_EMIT = 3'd4;
  localparam state_t ST_MEM_ADDR = 3'd5;
  localparam state_t ST_MEM_EMIT = 3'd6;
  localparam state_t ST_DONE     = 3'd7;

  localparam logic [15:0] DUMP_HEADER_TAG = 16'hDB60;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 139;
  localparam int EX_MEM_W = 76;
  localparam int MEM_WB_W = 71;

  localparam int IF_ID_WORDS  = 2;
  localparam int ID_EX_WORDS  = 5;
  localparam int EX_MEM_WORDS = 3;
  localparam int MEM_WB_WORDS = 3;
  localparam int LATCH_WORDS  = IF_ID_WORDS + ID_EX_WORDS + EX_MEM_WORDS + MEM_WB_WORDS;

  // Packed layout of the snapshot: IF_ID in the low bits, MEM_WB on top.
  localparam int IF_ID_OFS  = 0;
  localparam int ID_EX_OFS  = IF_ID_OFS + IF_ID_W;
  localparam int EX_MEM_OFS = ID_EX_OFS + ID_EX_W;
  localparam int MEM_WB_OFS = EX_MEM_OFS + EX_MEM_W;
  localparam int SNAP_W     = MEM_WB_OFS + MEM_WB_W;

endpackage

// File: rtl/latch_serializer.sv
// Holds the 350-bit latch snapshot and presents it as 13 zero-padded 32-bit
// words, each latch least-significant word first.
module latch_serializer
  import debug_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_capture,
  input  logic [IF_ID_W-1:0]  i_if_id,
  input  logic [ID_EX_W-1:0]  i_id_ex,
  input  logic [EX_MEM_W-1:0] i_ex_mem,
  input  logic [MEM_WB_W-1:0] i_mem_wb,
  input  logic [3:0]          i_word_idx,
  output logic [31:0]         o_word
);

  logic [SNAP_W-1:0]         snap_q;
  logic [LATCH_WORDS*32-1:0] padded;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      snap_q <= '0;
    end else if (i_capture) begin
      snap_q <= {i_mem_wb, i_ex_mem, i_id_ex, i_if_id};
    end
  end

  // Each latch padded up to a whole number of words so indices map directly.
  assign padded = {{(32*MEM_WB_WORDS-MEM_WB_W){1'b0}}, snap_q[MEM_WB_OFS +: MEM_WB_W],
                   {(32*EX_MEM_WORDS-EX_MEM_W){1'b0}}, snap_q[EX_MEM_OFS +: EX_MEM_W],
                   {(32*ID_EX_WORDS-ID_EX_W){1'b0}},   snap_q[ID_EX_OFS +: ID_EX_W],
                   snap_q[IF_ID_OFS +: IF_ID_W]};

  always_comb begin
    o_word = '0;
    for (int k = 0; k < LATCH_WORDS; k++) begin
      if (i_word_idx == 4'(k)) o_word = padded[k*32 +: 32];
    end
  end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams header, latch snapshot, register file and a data-memory window into
// the UART TX FIFO, one word per accepted write, honouring FIFO back-pressure.
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter int          N_REGS    = 32,
  parameter logic [31:0] MEM_BASE  = 32'h0,
  parameter int          MEM_WORDS = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [63:0]   i_IF_ID_latch,
  input  logic [138:0]  i_ID_EX_latch,
  input  logic [75:0]   i_EX_MEM_latch,
  input  logic [70:0]   i_MEM_WB_latch,
  output logic [4:0]    o_reg_addr_to_read,
  input  logic [31:0]   i_register_content,
  output logic [31:0]   o_addr_to_read_mem_data,
  input  logic [31:0]   i_mem_data_content,
  input  logic          i_fifo_full,
  output logic [31:0]   o_data_to_fifo,
  output logic          o_write_en_fifo,
  output logic          o_busy,
  output logic          o_done
);

  localparam int          TOTAL_WORDS = 1 + LATCH_WORDS + N_REGS + MEM_WORDS;
  localparam logic [31:0] HEADER_WORD = {DUMP_HEADER_TAG, 16'(TOTAL_WORDS)};
  localparam logic [31:0] LATCH_LAST  = 32'(LATCH_WORDS - 1);
  localparam logic [31:0] REG_LAST    = 32'(N_REGS - 1);
  localparam logic [31:0] MEM_LAST    = 32'(MEM_WORDS - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        emit, wr, capture;
  logic [3:0]  ser_idx;
  logic [31:0] ser_word;

  assign emit    = (state_q == ST_HEADER) || (state_q == ST_LATCH) ||
                   (state_q == ST_REG_EMIT) || (state_q == ST_MEM_EMIT);
  assign wr      = emit && !i_fifo_full;
  assign capture = (state_q == ST_IDLE) && i_start;
  // Look one word ahead so the next latch word is loaded on the write edge.
  assign ser_idx = (state_q == ST_HEADER) ? 4'd0 : 4'(cnt_q + 32'd1);

  latch_serializer u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_capture  (capture),
    .i_if_id    (i_IF_ID_latch),
    .i_id_ex    (i_ID_EX_latch),
    .i_ex_mem   (i_EX_MEM_latch),
    .i_mem_wb   (i_MEM_WB_latch),
    .i_word_idx (ser_idx),
    .o_word     (ser_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d = ST_HEADER;
        data_d  = HEADER_WORD;
        cnt_d   = '0;
      end
      ST_HEADER: if (wr) begin
        state_d = ST_LATCH;
        data_d  = ser_word;
        cnt_d   = '0;
      end
      ST_LATCH: if (wr) begin
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_REG_ADDR;
          cnt_d   = '0;
        end else begin
          data_d = ser_word;
          cnt_d  = cnt_q + 32'd1;
        end
      end
      ST_REG_ADDR: begin
        state_d = ST_REG_EMIT;
        data_d  = i_register_content;
      end
      ST_REG_EMIT: if (wr) begin
        if (cnt_q == REG_LAST) begin
          cnt_d   = '0;
          state_d = (MEM_WORDS == 0) ? ST_DONE : ST_MEM_ADDR;
        end else begin
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_REG_ADDR;
        end
      end
      ST_MEM_ADDR: begin
        state_d = ST_MEM_EMIT;
        data_d  = i_mem_data_content;
      end
      ST_MEM_EMIT: if (wr) begin
        if (cnt_q == MEM_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_MEM_ADDR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        data_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign o_reg_addr_to_read = ((state_q == ST_REG_ADDR) || (state_q == ST_REG_EMIT))
                              ? cnt_q[4:0] : 5'd0;
  assign o_addr_to_read_mem_data = ((state_q == ST_MEM_ADDR) || (state_q == ST_MEM_EMIT))
                                   ? (MEM_BASE + {cnt_q[29:0], 2'b00}) : 32'd0;
  assign o_data_to_fifo  = data_q;
  assign o_write_en_fifo = wr;
  assign o_busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done          = (state_q == ST_DONE);

endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Controller that sequences a full state dump of the halted pipeline into the UART TX FIFO, word by word.
- On a start pulse from the debug unit it emits the following, in order:
  - one header word;
  - four snapshotted inter-stage latches, serialised to 32-bit words;
  - the register file, read through the pipeline's register read port;
  - a window of data memory, read through the debug memory read port.
- It owns the register and memory debug read ports and the FIFO write port while busy, and respects FIFO back-pressure.

Parameters:
- N_REGS, 32, number of registers dumped (indices 0..N_REGS-1).
- MEM_BASE, 0, byte address of the first data-memory word dumped.
- MEM_WORDS, 32, number of consecutive 32-bit memory words dumped; address step is 4.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request to begin a dump.
- i_IF_ID_latch  in  64  IF/ID latch.
- i_ID_EX_latch  in  139  ID/EX latch.
- i_EX_MEM_latch  in  76  EX/MEM latch.
- i_MEM_WB_latch  in  71  MEM/WB latch.
- o_reg_addr_to_read  out  5  register index presented to the pipeline.
- i_register_content  in  32  register data; valid one cycle after the address.
- o_addr_to_read_mem_data  out  32  memory byte address presented to the pipeline.
- i_mem_data_content  in  32  memory data; valid one cycle after the address.
- i_fifo_full  in  1  TX FIFO cannot accept a write this cycle.
- o_data_to_fifo  out  32  word to write.
- o_write_en_fifo  out  1  FIFO write strobe.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse after the last word is written.

Behaviour:
- Reset (i_reset=0, asynchronous): state IDLE; all outputs 0; counters and snapshot cleared.
- Release of reset is synchronous to i_clk.
- IDLE:
  - i_start=1 captures all four latches into a 350-bit snapshot register.
  - Next state is HEADER; o_busy=1 from the next cycle.
- Header word is {16'hDB60, 16'(TOTAL_WORDS)}, where TOTAL_WORDS = 1 + 13 + N_REGS + MEM_WORDS (78 at defaults).
- Latch serialisation:
  - Each latch is zero-extended to a multiple of 32 bits and emitted least-significant word first.
  - Word counts: IF_ID 2, ID_EX 5, EX_MEM 3, MEM_WB 3.
  - Order: IF_ID, ID_EX, EX_MEM, MEM_WB.
- States: IDLE, HEADER, LATCH, REG_ADDR, REG_EMIT, MEM_ADDR, MEM_EMIT, DONE.
- Emit rule (HEADER, LATCH, REG_EMIT, MEM_EMIT):
  - o_data_to_fifo holds the registered current word.
  - o_write_en_fifo = ~i_fifo_full, combinational, asserted only in emit states.
  - The sequencer advances only on a cycle where the write occurs.
  - While i_fifo_full=1 it holds the word and the state indefinitely; no word is lost or duplicated.
- HEADER and LATCH sustain one word per cycle when the FIFO is not full.
- REG_ADDR:
  - Drives o_reg_addr_to_read = reg index for one cycle.
  - REG_EMIT then captures i_register_content and keeps the address stable until the write.
  - Best case two cycles per register; after reg N_REGS-1, go to MEM_ADDR.
- MEM_ADDR / MEM_EMIT:
  - Same scheme, with o_addr_to_read_mem_data = MEM_BASE + 4*i.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
- DONE: o_done=1 for one cycle, o_busy=0, read-address outputs return to 0, then IDLE.
- i_start while busy is ignored; i_start in the DONE cycle is ignored.
- The snapshot is not refreshed mid-dump; latch input changes during a dump do not affect output.
- Reset mid-dump aborts immediately. Words already written stay in the FIFO; the next dump starts with a fresh header.
- If MEM_WORDS=0, the sequencer skips from the last register straight to DONE.

Decomposition:
- Shared package debug_pkg holds:
  - state enum;
  - DUMP_HEADER_TAG=16'hDB60;
  - latch widths (64/139/76/71) and per-latch word counts (2/5/3/3);
  - LATCH_WORDS=13.
- One natural sub-module, latch_serializer: snapshot register plus a word-index mux that yields the 32-bit word for index 0..12.

Test Plan:
1. Defaults, FIFO never full, start pulse → exactly 78 writes. Word0=32'hDB60004E; words 1-2 = IF_ID[31:0], IF_ID[63:32]; o_done one cycle after write 78.
2. ID_EX=139'h7_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF → LATCH words 3-6 = 32'hFFFFFFFF, word 7 = 32'h00000007 (zero-padded).
3. i_register_content=index*3 and mem model returning address → reg words are 0,3,...,93; mem words 0x00,0x04,...,0x7C; o_reg_addr_to_read is stable for each capture.
4. i_fifo_full toggled randomly, held high for 50 cycles mid-register phase → same 78-word sequence as test 1, with no duplicates or drops and o_write_en_fifo never high while full.
5. i_start re-pulsed during busy, and again during DONE → ignored; only one dump of 78 words.
6. i_reset low at write 20 → all outputs 0 asynchronously; after release, a new start produces a full 78-word dump beginning with the header.
